// File: rtl/line_burst_pkg.sv
// rtl/line_burst_pkg.sv - shared types and default geometry for the line burst responder
package line_burst_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] beat_idx_t;

endpackage

// File: rtl/line_beat_buffer.sv
// rtl/line_beat_buffer.sv - line register with full-line load, per-beat write and indexed beat read
module line_beat_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [IDX_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] beat_wdata,
    output logic [LINE_W-1:0] line,
    output logic [BEAT_W-1:0] beat_rdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (load) begin
            line <= load_line;
        end else if (beat_we) begin
            line[int'(beat_idx)*BEAT_W +: BEAT_W] <= beat_wdata;
        end
    end

    assign beat_rdata = line[int'(beat_idx)*BEAT_W +: BEAT_W];

endmodule

// File: rtl/line_burst_responder.sv
// rtl/line_burst_responder.sv - serves whole-line pmem requests as beat bursts; LINE_BURST_PERF_EN adds perf counters
module line_burst_responder #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [ADDR_W-1:0] burst_address,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
`ifdef LINE_BURST_PERF_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    import line_burst_pkg::*;

    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W   = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              beat_xfer;
    logic              last_xfer;
    logic              buf_load;
    logic              buf_we;
    logic [LINE_W-1:0] buf_line;
    logic [BEAT_W-1:0] buf_beat;
    logic [LINE_W-1:0] merged_line;

    assign beat_xfer = ((state == RD) || (state == WR)) && burst_resp;
    assign last_xfer = beat_xfer && (cnt == LAST_BEAT);
    assign buf_load  = (state == IDLE) && pmem_write;
    assign buf_we    = (state == RD) && burst_resp;

    line_beat_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_line  (pmem_wdata),
        .beat_we    (buf_we),
        .beat_idx   (cnt),
        .beat_wdata (burst_rdata),
        .line       (buf_line),
        .beat_rdata (buf_beat)
    );

    // The final read beat is still in flight on the bus, so fold it in when publishing the line.
    always_comb begin
        merged_line = buf_line;
        merged_line[int'(cnt)*BEAT_W +: BEAT_W] = burst_rdata;
    end

    always_comb begin
        state_next  = state;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        pmem_resp   = 1'b0;
        burst_wdata = '0;
        case (state)
            IDLE: begin
                if (pmem_write) begin
                    state_next = WR;
                end else if (pmem_read) begin
                    state_next = RD;
                end
            end
            RD: begin
                burst_read = 1'b1;
                if (last_xfer) begin
                    state_next = DONE;
                end
            end
            WR: begin
                burst_write = 1'b1;
                burst_wdata = buf_beat;
                if (last_xfer) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                pmem_resp  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            burst_address <= '0;
            pmem_rdata    <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && (pmem_read || pmem_write)) begin
                burst_address <= pmem_address & ADDR_MASK;
            end
            if (beat_xfer) begin
                cnt <= last_xfer ? '0 : cnt + CNT_W'(1);
            end
            if ((state == RD) && last_xfer) begin
                pmem_rdata <= merged_line;
            end
        end
    end

`ifdef LINE_BURST_PERF_EN
    logic op_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr          <= 1'b0;
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (state == IDLE) begin
                op_wr <= pmem_write;
            end
            if ((state == DONE) && !op_wr && (perf_rd_cnt != 32'hFFFF_FFFF)) begin
                perf_rd_cnt <= perf_rd_cnt + 32'd1;
            end
            if ((state == DONE) && op_wr && (perf_wr_cnt != 32'hFFFF_FFFF)) begin
                perf_wr_cnt <= perf_wr_cnt + 32'd1;
            end
            if (((state == RD) || (state == WR)) && !burst_resp
                && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_burst_responder.sv
// tb/tb_line_burst_responder.sv - scoreboard bench for line_burst_responder
module tb_line_burst_responder;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          burst_read;
    logic          burst_write;
    logic [AW-1:0] burst_address;
    logic [BW-1:0] burst_wdata;
    logic [BW-1:0] burst_rdata;
    logic          burst_resp;
`ifdef LINE_BURST_PERF_EN
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] exp_beat_q[$];
    logic [LW-1:0] exp_line_q[$];

    line_burst_responder #(.LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
`ifdef LINE_BURST_PERF_EN
        ,
        .perf_rd_cnt    (perf_rd_cnt),
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"}, burst_read, 1'b0);
        check({tag, "_wr"}, burst_write, 1'b0);
        check({tag, "_resp"}, pmem_resp, 1'b0);
    endtask

    // pat bit i gives burst_resp for the i-th burst cycle; cycles beyond pat_len strobe every cycle.
    task automatic run_burst(input bit do_wr, input bit do_rd, input logic [AW-1:0] addr,
                             input logic [LW-1:0] line, input logic [15:0] pat,
                             input int pat_len, input bit hold);
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_line;
        bit            is_wr;
        bit            r;
        int            beat;
        int            pi;
        exp_addr = addr & ~32'h1F;
        exp_line = '0;
        is_wr    = do_wr;
        beat     = 0;
        pi       = 0;
        pmem_write   = do_wr;
        pmem_read    = do_rd;
        pmem_address = addr;
        pmem_wdata   = do_wr ? line : {8{$urandom}};
        if (is_wr) begin
            for (int k = 0; k < NB; k++) exp_beat_q.push_back(line[k*BW +: BW]);
        end else begin
            exp_line_q.push_back(line);
        end
        tick();
        if (!hold) begin
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = $urandom;
            pmem_wdata   = {8{$urandom}};
        end
        while (beat < NB && pi < 40) begin
            r = (pi < pat_len) ? pat[pi] : 1'b1;
            check("strobe", is_wr ? burst_write : burst_read, 1'b1);
            check("other_strobe", is_wr ? burst_read : burst_write, 1'b0);
            check("burst_addr", burst_address, exp_addr);
            check("resp_early", pmem_resp, 1'b0);
            burst_resp = r;
            if (r) begin
                if (is_wr) begin
                    if (exp_beat_q.size() == 0) check("beat_q_empty", 1'b1, 1'b0);
                    else check("wdata", burst_wdata, exp_beat_q.pop_front());
                end
                burst_rdata = line[beat*BW +: BW];
                beat++;
            end else begin
                burst_rdata = {$urandom, $urandom};
            end
            tick();
            pi++;
        end
        burst_resp  = 1'b0;
        burst_rdata = '0;
        check("pmem_resp", pmem_resp, 1'b1);
        check("strobe_fall", burst_read | burst_write, 1'b0);
        if (!is_wr) begin
            if (exp_line_q.size() == 0) check("line_q_empty", 1'b1, 1'b0);
            else begin
                exp_line = exp_line_q.pop_front();
                check("rdata", pmem_rdata, exp_line);
            end
        end
        tick();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        check_idle_outputs("after_done");
        if (!is_wr) check("rdata_hold", pmem_rdata, exp_line);
    endtask

    logic [LW-1:0] line_a;
    logic [LW-1:0] line_w;
    logic [LW-1:0] line_r;
`ifdef LINE_BURST_PERF_EN
    logic [31:0]   rd_before;
`endif

    initial begin
        rst = 1'b1; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
        burst_rdata = '0; burst_resp = 0;
        tick(); tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        check("reset_rdata", pmem_rdata, '0);
        check("reset_addr", burst_address, '0);
        check("reset_wdata", burst_wdata, '0);

        line_a = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
        run_burst(1'b0, 1'b1, 32'h0000_1234, line_a, 16'h0, 0, 1'b0);

        line_w = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        run_burst(1'b1, 1'b0, 32'h0000_5678, line_w, 16'h0, 0, 1'b0);
        check("rdata_kept_by_write", pmem_rdata, line_a);

        line_r = {8{$urandom}};
        run_burst(1'b0, 1'b1, 32'h4000_00FF, line_r, 16'b1011001, 7, 1'b0);

        run_burst(1'b1, 1'b1, 32'h0000_9ABC, {8{$urandom}}, 16'b0101, 4, 1'b0);
        check("rdata_kept_by_both", pmem_rdata, line_r);

        // Reset after the 2nd write beat
        exp_beat_q.delete();
        pmem_write = 1'b1; pmem_address = 32'h0000_0040; pmem_wdata = line_w;
        tick();
        pmem_write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            burst_resp = 1'b1;
            check("rst_pre_wdata", burst_wdata, line_w[k*BW +: BW]);
            tick();
        end
        burst_resp = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("post_rst");
        check("post_rst_addr", burst_address, '0);
        check("post_rst_wdata", burst_wdata, '0);
        check("post_rst_rdata", pmem_rdata, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle_outputs("post_rst_quiet");
        end
        run_burst(1'b0, 1'b1, 32'h0000_2000, {8{$urandom}}, 16'b110, 3, 1'b0);

        // Request held through DONE must not start a second burst
`ifdef LINE_BURST_PERF_EN
        rd_before = perf_rd_cnt;
`endif
        run_burst(1'b0, 1'b1, 32'h0000_3000, {8{$urandom}}, 16'h0, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle_outputs("no_rerun");
        end
`ifdef LINE_BURST_PERF_EN
        check("perf_rd_inc", perf_rd_cnt, rd_before + 32'd1);
`endif
        check("beat_q_drained", exp_beat_q.size(), 0);
        check("line_q_drained", exp_line_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
